// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round controller and its datapath.
package baccarat_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CARDS_W = 9;

  // Light pair is {player_win_light, dealer_win_light}
  localparam logic [1:0] WIN_PLAYER = 2'b10;
  localparam logic [1:0] WIN_DEALER = 2'b01;
  localparam logic [1:0] WIN_TIE    = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    DEAL  = 3'd2,
    TALLY = 3'd3,
    SHOW  = 3'd4,
    SHUF  = 3'd5
  } round_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over inc.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Round-level controller: paces the dealing machine with step pulses, tallies
// outcomes from the win lights and requests a reshuffle when the shoe runs low.
module round_scheduler
  import baccarat_pkg::*;
#(
  parameter int unsigned SHOE_LIMIT  = 300,
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               deal_req,
  input  logic               card_loaded,
  input  logic               player_win_light,
  input  logic               dealer_win_light,
  input  logic               shuffle_done,
  output logic               step,
  output logic               round_rst,
  output logic               shuffle_req,
  output logic               result_valid,
  output logic [CNT_W-1:0]   player_wins,
  output logic [CNT_W-1:0]   dealer_wins,
  output logic [CNT_W-1:0]   ties,
  output logic [CNT_W-1:0]   rounds,
  output logic [CARDS_W-1:0] cards_used
);

  localparam int unsigned TMR_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD =
    (AUTO_PERIOD > 0) ? TMR_W'(AUTO_PERIOD - 1) : '0;

  round_state_t     state;
  round_state_t     next_state;
  logic [1:0]       lights;
  logic [1:0]       lights_q;
  logic [TMR_W-1:0] tmr;
  logic             load_win;
  logic             step_next;
  logic             player_inc;
  logic             dealer_inc;
  logic             tie_inc;
  logic             round_inc;
  logic             cards_inc;
  logic             cards_clr;

  assign lights    = {player_win_light, dealer_win_light};
  assign cards_inc = load_win & card_loaded;
  assign cards_clr = reset | ((state == SHUF) & shuffle_done);

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Win lights in DEAL take priority over a same-cycle deal_req
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (deal_req) next_state = CLR;
      CLR:     next_state = DEAL;
      DEAL:    if (|lights) next_state = TALLY;
      TALLY:   next_state = SHOW;
      SHOW: begin
        if (deal_req) begin
          next_state = (32'(cards_used) >= SHOE_LIMIT) ? SHUF : CLR;
        end
      end
      SHUF:    if (shuffle_done) next_state = CLR;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    step_next  = 1'b0;
    player_inc = 1'b0;
    dealer_inc = 1'b0;
    tie_inc    = 1'b0;
    round_inc  = 1'b0;
    if ((state == DEAL) && (next_state == DEAL)) begin
      step_next = (AUTO_PERIOD == 0) ? deal_req : (tmr == '0);
    end
    if (state == TALLY) begin
      round_inc  = 1'b1;
      player_inc = (lights_q == WIN_PLAYER);
      dealer_inc = (lights_q == WIN_DEALER);
      tie_inc    = (lights_q == WIN_TIE);
    end
  end

  // Registered outputs, card-load window and auto-step timer
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      step         <= 1'b0;
      round_rst    <= 1'b1;
      shuffle_req  <= 1'b0;
      result_valid <= 1'b0;
      load_win     <= 1'b0;
      lights_q     <= 2'b00;
      tmr          <= '0;
    end else begin
      step         <= step_next;
      round_rst    <= (next_state == CLR);
      shuffle_req  <= (next_state == SHUF);
      result_valid <= (next_state == SHOW);
      load_win     <= step;
      if (state == DEAL) begin
        lights_q <= lights;
      end
      if ((next_state == DEAL) && ((state != DEAL) || (tmr == '0))) begin
        tmr <= TMR_RELOAD;
      end else if (state == DEAL) begin
        tmr <= tmr - TMR_W'(1);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_player_wins (
    .clk(slow_clock), .clear(reset), .inc(player_inc), .count(player_wins)
  );

  sat_counter #(.WIDTH(CNT_W)) u_dealer_wins (
    .clk(slow_clock), .clear(reset), .inc(dealer_inc), .count(dealer_wins)
  );

  sat_counter #(.WIDTH(CNT_W)) u_ties (
    .clk(slow_clock), .clear(reset), .inc(tie_inc), .count(ties)
  );

  sat_counter #(.WIDTH(CNT_W)) u_rounds (
    .clk(slow_clock), .clear(reset), .inc(round_inc), .count(rounds)
  );

  sat_counter #(.WIDTH(CARDS_W)) u_cards_used (
    .clk(slow_clock), .clear(cards_clr), .inc(cards_inc), .count(cards_used)
  );

endmodule

// File: tb/tb_round_scheduler.sv
// Bench for round_scheduler: a manual-mode instance (shoe limit 6) and an
// auto-mode instance (period 3), each followed cycle by cycle by a round-level model.
module tb_round_scheduler;

  localparam int LIM0 = 6;
  localparam int LIM1 = 300;
  localparam int PER1 = 3;

  localparam int P_IDLE  = 0;
  localparam int P_CLR   = 1;
  localparam int P_DEAL  = 2;
  localparam int P_TALLY = 3;
  localparam int P_SHOW  = 4;
  localparam int P_SHUF  = 5;

  logic       slow_clock = 1'b0;
  logic       reset[2];
  logic       deal_req[2];
  logic       card_loaded[2];
  logic       pwl[2];
  logic       dwl[2];
  logic       shuffle_done[2];
  logic       step[2];
  logic       round_rst[2];
  logic       shuffle_req[2];
  logic       result_valid[2];
  logic [7:0] player_wins[2];
  logic [7:0] dealer_wins[2];
  logic [7:0] ties[2];
  logic [7:0] rounds[2];
  logic [8:0] cards_used[2];

  int n_cmp = 0;
  int n_bad = 0;

  // Round-level model state
  int m_ph[2], m_age[2], m_lights[2];
  int m_pw[2], m_dw[2], m_ti[2], m_ro[2], m_cards[2];
  bit m_step[2], m_prev_step[2], m_rr[2], m_sreq[2], m_rv[2], m_valid[2];

  always #5 slow_clock = ~slow_clock;

  round_scheduler #(.SHOE_LIMIT(LIM0), .AUTO_PERIOD(0)) u_man (
    .slow_clock(slow_clock), .reset(reset[0]), .deal_req(deal_req[0]),
    .card_loaded(card_loaded[0]), .player_win_light(pwl[0]),
    .dealer_win_light(dwl[0]), .shuffle_done(shuffle_done[0]),
    .step(step[0]), .round_rst(round_rst[0]), .shuffle_req(shuffle_req[0]),
    .result_valid(result_valid[0]), .player_wins(player_wins[0]),
    .dealer_wins(dealer_wins[0]), .ties(ties[0]), .rounds(rounds[0]),
    .cards_used(cards_used[0])
  );

  round_scheduler #(.SHOE_LIMIT(LIM1), .AUTO_PERIOD(PER1)) u_auto (
    .slow_clock(slow_clock), .reset(reset[1]), .deal_req(deal_req[1]),
    .card_loaded(card_loaded[1]), .player_win_light(pwl[1]),
    .dealer_win_light(dwl[1]), .shuffle_done(shuffle_done[1]),
    .step(step[1]), .round_rst(round_rst[1]), .shuffle_req(shuffle_req[1]),
    .result_valid(result_valid[1]), .player_wins(player_wins[1]),
    .dealer_wins(dealer_wins[1]), .ties(ties[1]), .rounds(rounds[1]),
    .cards_used(cards_used[1])
  );

  function automatic int period_of(input int i);
    return (i == 0) ? 0 : PER1;
  endfunction

  function automatic int limit_of(input int i);
    return (i == 0) ? LIM0 : LIM1;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the inputs seen at that edge
  task automatic model_tick(input int i);
    int nph;
    bit nstep;
    int inc;
    if (reset[i]) begin
      m_ph[i] = P_IDLE; m_age[i] = 0; m_lights[i] = 0;
      m_pw[i] = 0; m_dw[i] = 0; m_ti[i] = 0; m_ro[i] = 0; m_cards[i] = 0;
      m_step[i] = 0; m_prev_step[i] = 0; m_rr[i] = 1; m_sreq[i] = 0; m_rv[i] = 0;
      m_valid[i] = 1;
      return;
    end
    inc   = (m_prev_step[i] && card_loaded[i]) ? 1 : 0;
    nph   = m_ph[i];
    nstep = 0;
    case (m_ph[i])
      P_IDLE: if (deal_req[i]) nph = P_CLR;
      P_CLR: begin
        nph = P_DEAL;
        m_age[i] = 0;
      end
      P_DEAL: begin
        if (pwl[i] || dwl[i]) begin
          nph = P_TALLY;
          m_lights[i] = (pwl[i] ? 2 : 0) + (dwl[i] ? 1 : 0);
        end else begin
          m_age[i]++;
          if (period_of(i) == 0) nstep = deal_req[i];
          else nstep = ((m_age[i] % period_of(i)) == 0);
        end
      end
      P_TALLY: begin
        m_ro[i] = sat(m_ro[i] + 1, 255);
        if (m_lights[i] == 2) m_pw[i] = sat(m_pw[i] + 1, 255);
        if (m_lights[i] == 1) m_dw[i] = sat(m_dw[i] + 1, 255);
        if (m_lights[i] == 3) m_ti[i] = sat(m_ti[i] + 1, 255);
        nph = P_SHOW;
      end
      P_SHOW: if (deal_req[i]) nph = (m_cards[i] >= limit_of(i)) ? P_SHUF : P_CLR;
      P_SHUF: if (shuffle_done[i]) nph = P_CLR;
      default: nph = P_IDLE;
    endcase
    if (m_ph[i] == P_SHUF && shuffle_done[i]) m_cards[i] = 0;
    else m_cards[i] = sat(m_cards[i] + inc, 511);
    m_prev_step[i] = m_step[i];
    m_step[i] = nstep;
    m_rr[i]   = (nph == P_CLR);
    m_sreq[i] = (nph == P_SHUF);
    m_rv[i]   = (nph == P_SHOW);
    m_ph[i]   = nph;
  endtask

  always @(posedge slow_clock) begin
    for (int i = 0; i < 2; i++) model_tick(i);
  end

  always @(negedge slow_clock) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        check($sformatf("step[%0d]", i),         32'(step[i]),         32'(m_step[i]));
        check($sformatf("round_rst[%0d]", i),    32'(round_rst[i]),    32'(m_rr[i]));
        check($sformatf("shuffle_req[%0d]", i),  32'(shuffle_req[i]),  32'(m_sreq[i]));
        check($sformatf("result_valid[%0d]", i), 32'(result_valid[i]), 32'(m_rv[i]));
        check($sformatf("player_wins[%0d]", i),  32'(player_wins[i]),  32'(m_pw[i]));
        check($sformatf("dealer_wins[%0d]", i),  32'(dealer_wins[i]),  32'(m_dw[i]));
        check($sformatf("ties[%0d]", i),         32'(ties[i]),         32'(m_ti[i]));
        check($sformatf("rounds[%0d]", i),       32'(rounds[i]),       32'(m_ro[i]));
        check($sformatf("cards_used[%0d]", i),   32'(cards_used[i]),   32'(m_cards[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge slow_clock);
  endtask

  task automatic start_round(input int i);
    deal_req[i] = 1'b1;
    tick(1);
    deal_req[i] = 1'b0;
    tick(2);
  endtask

  task automatic deal_card(input int i);
    deal_req[i] = 1'b1;
    tick(1);
    deal_req[i] = 1'b0;
    tick(1);
    card_loaded[i] = 1'b1;
    tick(1);
    card_loaded[i] = 1'b0;
  endtask

  task automatic end_round(input int i, input logic [1:0] lt);
    {pwl[i], dwl[i]} = lt;
    tick(3);
    {pwl[i], dwl[i]} = 2'b00;
  endtask

  initial begin
    int nreq;
    int nst;
    int first_k;
    int last_k;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; deal_req[i] = 1'b0; card_loaded[i] = 1'b0;
      pwl[i] = 1'b0; dwl[i] = 1'b0; shuffle_done[i] = 1'b0;
    end

    // Reset then idle
    tick(2);
    check("rst_round_rst", 32'(round_rst[0]), 32'd1);
    check("rst_step", 32'(step[0]), 32'd0);
    reset[0] = 1'b0;
    tick(1);
    check("idle_round_rst", 32'(round_rst[0]), 32'd0);
    tick(2);
    deal_req[0] = 1'b1;
    tick(1);
    check("clr_round_rst", 32'(round_rst[0]), 32'd1);
    tick(1);
    deal_req[0] = 1'b0;
    check("deal_round_rst", 32'(round_rst[0]), 32'd0);
    check("deal_no_step_from_clr_req", 32'(step[0]), 32'd0);

    // Manual player win: back-to-back pair, two singles, a stray load
    deal_req[0] = 1'b1;
    tick(1);
    check("b2b_step1", 32'(step[0]), 32'd1);
    tick(1);
    check("b2b_step2", 32'(step[0]), 32'd1);
    deal_req[0] = 1'b0; card_loaded[0] = 1'b1;
    tick(2);
    card_loaded[0] = 1'b0;
    deal_card(0);
    deal_card(0);
    card_loaded[0] = 1'b1;
    tick(1);
    card_loaded[0] = 1'b0;
    {pwl[0], dwl[0]} = 2'b10; deal_req[0] = 1'b1;
    tick(1);
    deal_req[0] = 1'b0;
    check("light_beats_req_step", 32'(step[0]), 32'd0);
    tick(2);
    {pwl[0], dwl[0]} = 2'b00;
    check("r1_cards", 32'(cards_used[0]), 32'd4);
    check("r1_player", 32'(player_wins[0]), 32'd1);
    check("r1_rounds", 32'(rounds[0]), 32'd1);
    check("r1_result_valid", 32'(result_valid[0]), 32'd1);

    // Tie round pushes the shoe past the limit
    start_round(0);
    shuffle_done[0] = 1'b1;
    tick(1);
    shuffle_done[0] = 1'b0;
    for (int c = 0; c < 4; c++) deal_card(0);
    end_round(0, 2'b11);
    check("r2_cards", 32'(cards_used[0]), 32'd8);
    check("r2_ties", 32'(ties[0]), 32'd1);

    // Shuffle with acknowledge withheld
    deal_req[0] = 1'b1;
    tick(1);
    deal_req[0] = 1'b0;
    nreq = 0;
    for (int k = 0; k < 5; k++) begin
      if (shuffle_req[0]) nreq++;
      if (k == 4) shuffle_done[0] = 1'b1;
      tick(1);
    end
    shuffle_done[0] = 1'b0;
    check("shuf_req_cycles", 32'(nreq), 32'd5);
    check("shuf_req_dropped", 32'(shuffle_req[0]), 32'd0);
    check("shuf_cards_cleared", 32'(cards_used[0]), 32'd0);
    check("shuf_round_rst", 32'(round_rst[0]), 32'd1);
    tick(1);
    end_round(0, 2'b01);
    check("r3_dealer", 32'(dealer_wins[0]), 32'd1);
    check("r3_rounds", 32'(rounds[0]), 32'd3);

    // Tally saturation
    for (int r = 0; r < 257; r++) begin
      start_round(0);
      end_round(0, 2'b10);
    end
    check("sat_player", 32'(player_wins[0]), 32'd255);
    check("sat_rounds", 32'(rounds[0]), 32'd255);
    check("sat_ties_kept", 32'(ties[0]), 32'd1);

    // cards_used saturation with continuous stepping
    start_round(0);
    deal_req[0] = 1'b1; card_loaded[0] = 1'b1;
    tick(520);
    deal_req[0] = 1'b0;
    tick(2);
    card_loaded[0] = 1'b0;
    check("sat_cards", 32'(cards_used[0]), 32'd511);
    end_round(0, 2'b10);

    // Reset in the middle of a shuffle
    deal_req[0] = 1'b1;
    tick(1);
    deal_req[0] = 1'b0;
    tick(2);
    check("mid_shuf_req", 32'(shuffle_req[0]), 32'd1);
    reset[0] = 1'b1;
    tick(1);
    check("abort_shuf_req", 32'(shuffle_req[0]), 32'd0);
    check("abort_round_rst", 32'(round_rst[0]), 32'd1);
    check("abort_cards", 32'(cards_used[0]), 32'd0);
    check("abort_player", 32'(player_wins[0]), 32'd0);
    reset[0] = 1'b0;
    tick(1);
    check("abort_idle_round_rst", 32'(round_rst[0]), 32'd0);

    // Auto mode: step every 3rd DEAL cycle, deal_req ignored
    reset[1] = 1'b0;
    tick(1);
    card_loaded[1] = 1'b1;
    start_round(1);
    nst = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 9; k++) begin
      if (step[1]) begin
        nst++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      deal_req[1] = k[0];
      tick(1);
    end
    deal_req[1] = 1'b0;
    check("auto_step_count", 32'(nst), 32'd3);
    check("auto_first_step", 32'(first_k), 32'd2);
    check("auto_last_step", 32'(last_k), 32'd8);
    end_round(1, 2'b01);
    check("auto_cards", 32'(cards_used[1]), 32'd3);
    check("auto_dealer", 32'(dealer_wins[1]), 32'd1);

    // Auto mode: reset after the second step of the next round
    start_round(1);
    nst = 0;
    for (int k = 0; k < 20; k++) begin
      if (step[1]) nst++;
      if (nst == 2) break;
      tick(1);
    end
    check("auto_second_step_seen", 32'(nst), 32'd2);
    reset[1] = 1'b1;
    tick(1);
    check("auto_rst_step", 32'(step[1]), 32'd0);
    check("auto_rst_round_rst", 32'(round_rst[1]), 32'd1);
    check("auto_rst_cards", 32'(cards_used[1]), 32'd0);
    check("auto_rst_dealer", 32'(dealer_wins[1]), 32'd0);
    check("auto_rst_rounds", 32'(rounds[1]), 32'd0);
    reset[1] = 1'b0; card_loaded[1] = 1'b0;
    tick(2);
    check("auto_idle_round_rst", 32'(round_rst[1]), 32'd0);
    check("auto_idle_step", 32'(step[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
